// File: rtl/display_scan_hex.sv
// Multiplexed hex seven-segment scanner; all outputs registered, one cycle behind scan state.
// No backpressure: free-running scan, load strobe accepted every cycle.
module display_scan_hex #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   valor,
    input  logic                    carregar,
    input  logic                    apagar_zeros,
    input  logic [N_DIGITS-1:0]     pontos,
    output logic [0:6]              segmentos,
    output logic                    ponto,
    output logic [N_DIGITS-1:0]     anodos
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0] sombra_q, sombra_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [0:6]            seg_q, seg_d;
    logic                  ponto_q, ponto_d;
    logic [N_DIGITS-1:0]   anodos_q, anodos_d;

    logic [3:0]            nib;
    logic                  blank_lz;
    logic                  dp;
    logic                  all_zero;
    logic                  ghost;
    logic [N_DIGITS-1:0]   anod_sel;

    function automatic logic [0:6] hex7(input logic [3:0] n);
        logic [0:6] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        sombra_d = carregar ? valor : sombra_q;

        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Walk from the top digit down; a digit is a leading zero while everything above it is zero too.
        nib      = '0;
        blank_lz = 1'b0;
        dp       = 1'b0;
        all_zero = 1'b1;
        anod_sel = '1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (sombra_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nib         = sombra_q[4*i +: 4];
                blank_lz    = apagar_zeros && (i != 0) && all_zero;
                dp          = pontos[i];
                anod_sel[i] = 1'b0;
            end
        end

        ghost = (BLANK_CYC > 0) && (int'(cnt_q) < BLANK_CYC);

        anodos_d = '1;
        seg_d    = '1;
        ponto_d  = 1'b1;
        if (!ghost) begin
            anodos_d = anod_sel;
            seg_d    = blank_lz ? 7'b1111111 : hex7(nib);
            ponto_d  = ~dp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sombra_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= '1;
            ponto_q  <= 1'b1;
            anodos_q <= '1;
        end else begin
            sombra_q <= sombra_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            ponto_q  <= ponto_d;
            anodos_q <= anodos_d;
        end
    end

    assign segmentos = seg_q;
    assign ponto     = ponto_q;
    assign anodos    = anodos_q;

endmodule
